// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1R1W SRAM model.
package sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } sram_state_e;

  // Helpers work on a fixed maximum width; callers size-cast in and out.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_LANES  = 256;

  function automatic int num_wmask(input int width, input int gran);
    return (width + gran - 1) / gran;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] lane_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_LANES-1:0]  mask,
    input int                    gran
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < MAX_DATA_W; b++) begin
      if (mask[b / gran]) res[b] = new_word[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_1r1w_array.sv
// Raw storage: one lane-masked synchronous write port, one asynchronous read port.
module sram_1r1w_array import sram_pkg::*; #(
  parameter int DATA_WIDTH = 23,
  parameter int ADDR_WIDTH = 5,
  parameter int RAM_DEPTH  = 32,
  parameter int WMASK_GRAN = 8,
  localparam int NUM_WMASK = num_wmask(DATA_WIDTH, WMASK_GRAN)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [NUM_WMASK-1:0]  wmask,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] wr_word_d;

  always_comb begin
    wr_word_d = DATA_WIDTH'(lane_merge(MAX_DATA_W'(mem_q[waddr]), MAX_DATA_W'(wdata),
                                       MAX_LANES'(wmask), WMASK_GRAN));
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wr_word_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sram_1r1w_param.sv
// Parametrised 1R1W SRAM: power-on clear sequencer, collision bypass, 1- or 2-cycle read pipeline.
//   state | meaning
//   CLEAR | zeroing mem[clr_cnt] each cycle, ports ignored
//   READY | clear finished, read/write ports accepted
module sram_1r1w_param import sram_pkg::*; #(
  parameter int DATA_WIDTH = 23,
  parameter int ADDR_WIDTH = 5,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int WMASK_GRAN = 8,
  parameter int READ_LAT   = 1,
  parameter int BYPASS     = 1,
  localparam int NUM_WMASK = num_wmask(DATA_WIDTH, WMASK_GRAN)
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [NUM_WMASK-1:0]  wmask0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_vld,
  output logic                  init_done
);

  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("sram_1r1w_param: READ_LAT must be 1 or 2");
  end
  if (RAM_DEPTH < 1 || RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("sram_1r1w_param: RAM_DEPTH must be in 1..2**ADDR_WIDTH");
  end

  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata;
  logic [NUM_WMASK-1:0]  arr_wmask;
  logic                  wr_fire, rd_acc;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_vld_q, s1_vld_d;

  sram_1r1w_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH),
    .WMASK_GRAN (WMASK_GRAN)
  ) u_array (
    .clk   (clk0),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .wmask (arr_wmask),
    .raddr (addr1),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_fire   = (state_q == READY) && !csb0 && ({1'b0, addr0} < DEPTH_W);
    rd_acc    = (state_q == READY) && !csb1;
    arr_we    = wr_fire;
    arr_waddr = addr0;
    arr_wdata = din0;
    arr_wmask = wmask0;
    if (state_q == CLEAR) begin
      arr_we    = 1'b1;
      arr_waddr = clr_cnt_q;
      arr_wdata = '0;
      arr_wmask = '1;
      clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
      if (clr_cnt_q == LAST_ADDR) state_d = READY;
    end
    if (rst0) arr_we = 1'b0;

    rd_word = ({1'b0, addr1} < DEPTH_W) ? arr_rdata : '0;
    // Same-cycle write to the read address: forward the merged word when bypassing.
    if (BYPASS != 0 && wr_fire && addr0 == addr1) begin
      rd_word = DATA_WIDTH'(lane_merge(MAX_DATA_W'(rd_word), MAX_DATA_W'(din0),
                                       MAX_LANES'(wmask0), WMASK_GRAN));
    end
    s1_data_d = rd_acc ? rd_word : s1_data_q;
    s1_vld_d  = rd_acc;
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      s1_data_q <= '0;
      s1_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      s1_data_q <= s1_data_d;
      s1_vld_q  <= s1_vld_d;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
    logic                  s2_vld_q, s2_vld_d;

    always_comb begin
      s2_data_d = s1_vld_q ? s1_data_q : s2_data_q;
      s2_vld_d  = s1_vld_q;
    end

    always_ff @(posedge clk0) begin
      if (rst0) begin
        s2_data_q <= '0;
        s2_vld_q  <= 1'b0;
      end else begin
        s2_data_q <= s2_data_d;
        s2_vld_q  <= s2_vld_d;
      end
    end

    assign dout1     = s2_data_q;
    assign dout1_vld = s2_vld_q;
  end else begin : g_lat1
    assign dout1     = s1_data_q;
    assign dout1_vld = s1_vld_q;
  end

  assign init_done = (state_q == READY);

endmodule

// File: tb/tb_sram_1r1w_param.sv
// Scoreboard bench: two configurations (depth 32/lat 1/bypass, depth 24/lat 2/no bypass) share stimulus.
module tb_sram_1r1w_param;

  logic        clk, rst0, csb0, csb1;
  logic [4:0]  addr0, addr1;
  logic [22:0] din0;
  logic [2:0]  wmask0;
  logic [22:0] dout_a, dout_b;
  logic        vld_a, vld_b, done_a, done_b;

  sram_1r1w_param #(.DATA_WIDTH(23), .ADDR_WIDTH(5), .RAM_DEPTH(32), .WMASK_GRAN(8),
                    .READ_LAT(1), .BYPASS(1)) dut_a (
    .clk0(clk), .rst0(rst0), .csb0(csb0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
    .csb1(csb1), .addr1(addr1), .dout1(dout_a), .dout1_vld(vld_a), .init_done(done_a));

  sram_1r1w_param #(.DATA_WIDTH(23), .ADDR_WIDTH(5), .RAM_DEPTH(24), .WMASK_GRAN(8),
                    .READ_LAT(2), .BYPASS(0)) dut_b (
    .clk0(clk), .rst0(rst0), .csb0(csb0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
    .csb1(csb1), .addr1(addr1), .dout1(dout_b), .dout1_vld(vld_b), .init_done(done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [22:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [22:0] mem_m [2][32];
  bit          ready_m [2];
  int          clr_m [2];
  logic [22:0] last_exp [2];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;

  function automatic int depth_of(input int k); return (k == 1) ? 24 : 32; endfunction
  function automatic int lat_of(input int k);   return (k == 1) ? 2 : 1;   endfunction
  function automatic bit byp_of(input int k);   return (k == 1) ? 1'b0 : 1'b1; endfunction

  function automatic logic [22:0] merge(input logic [22:0] old_w, input logic [22:0] new_w,
                                        input logic [2:0] m);
    logic [23:0] bits;
    bits = 24'h0;
    for (int i = 0; i < 3; i++) if (m[i]) bits |= 24'hFF << (8 * i);
    return (old_w & ~bits[22:0]) | (new_w & bits[22:0]);
  endfunction

  // Reference behaviour at each rising edge, using the inputs sampled at that edge.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst0) begin
        ready_m[k]  = 1'b0;
        clr_m[k]    = 0;
        last_exp[k] = '0;
        for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].k == k) exp_q.delete(i);
      end else if (!ready_m[k]) begin
        clr_m[k]++;
        if (clr_m[k] == depth_of(k)) begin
          ready_m[k] = 1'b1;
          for (int a = 0; a < 32; a++) mem_m[k][a] = '0;
        end
      end else begin
        bit          wr;
        logic [22:0] rv;
        exp_t        e;
        wr = !csb0 && (int'(addr0) < depth_of(k));
        if (!csb1) begin
          rv = (int'(addr1) < depth_of(k)) ? mem_m[k][addr1] : 23'h0;
          if (wr && byp_of(k) && addr0 == addr1) rv = merge(rv, din0, wmask0);
          e.k = k; e.data = rv; e.due = cyc + lat_of(k) - 1;
          exp_q.push_back(e);
        end
        if (wr) mem_m[k][addr0] = merge(mem_m[k][addr0], din0, wmask0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic set_op(input bit w, input logic [4:0] wa, input logic [22:0] wd,
                        input logic [2:0] wm, input bit r, input logic [4:0] ra);
    csb0 = !w; addr0 = wa; din0 = wd; wmask0 = wm;
    csb1 = !r; addr1 = ra;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) set_op(1'b0, 5'd0, 23'h0, 3'b000, 1'b0, 5'd0);
  endtask

  task automatic rand_op(input bit allow);
    logic [4:0] wa;
    wa = 5'($urandom_range(0, 31));
    set_op(allow && ($urandom_range(0, 2) != 0), wa, 23'($urandom), 3'($urandom),
           allow && ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [22:0] dv;
        logic        vv, dn;
        int          idx;
        dv = (k == 1) ? dout_b : dout_a;
        vv = (k == 1) ? vld_b  : vld_a;
        dn = (k == 1) ? done_b : done_a;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) if (idx < 0 && exp_q[i].k == k) idx = i;

        checks++;
        if (dn !== ready_m[k]) begin
          errors++;
          $display("FAIL init_done dut%0d cyc %0d got %b exp %b", k, cyc, dn, ready_m[k]);
        end

        if (vv === 1'b1) begin
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL spurious_vld dut%0d cyc %0d got data %h exp no read", k, cyc, dv);
          end else begin
            if (exp_q[idx].due != cyc || dv !== exp_q[idx].data) begin
              errors++;
              $display("FAIL read_data dut%0d cyc %0d got %h exp %h (due cyc %0d)",
                       k, cyc, dv, exp_q[idx].data, exp_q[idx].due);
            end
            last_exp[k] = exp_q[idx].data;
            exp_q.delete(idx);
          end
        end else begin
          checks++;
          if (vv !== 1'b0 || dv !== last_exp[k]) begin
            errors++;
            $display("FAIL idle_hold dut%0d cyc %0d got vld %b data %h exp vld 0 data %h",
                     k, cyc, vv, dv, last_exp[k]);
          end
          if (idx >= 0 && exp_q[idx].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_vld dut%0d cyc %0d got vld 0 exp data %h",
                     k, cyc, exp_q[idx].data);
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      ready_m[k] = 1'b0; clr_m[k] = 0; last_exp[k] = '0;
      for (int a = 0; a < 32; a++) mem_m[k][a] = '0;
    end
    rst0 = 1'b1; csb0 = 1'b1; csb1 = 1'b1;
    addr0 = '0; addr1 = '0; din0 = '0; wmask0 = '0;
    tick();
    mon_en = 1'b1;
    tick();
    rst0 = 1'b0;

    // Requests during the clear window are ignored by both configurations.
    for (int i = 0; i < 24; i++) rand_op(1'b1);
    idle(10);

    for (int a = 0; a < 32; a++) set_op(1'b0, 5'd0, 23'h0, 3'b000, 1'b1, 5'(a));
    idle(3);

    // Masked lane write.
    set_op(1'b1, 5'd3, 23'h7FFFFF, 3'b111, 1'b0, 5'd0);
    set_op(1'b1, 5'd3, 23'h123456, 3'b010, 1'b0, 5'd0);
    set_op(1'b0, 5'd0, 23'h0, 3'b000, 1'b1, 5'd3);
    idle(3);

    // Collision on addr 5, then a plain read of it.
    set_op(1'b1, 5'd5, 23'h0000AA, 3'b111, 1'b0, 5'd0);
    set_op(1'b1, 5'd5, 23'h555555, 3'b111, 1'b1, 5'd5);
    set_op(1'b0, 5'd0, 23'h0, 3'b000, 1'b1, 5'd5);
    set_op(1'b1, 5'd7, 23'h3C3C3C, 3'b101, 1'b1, 5'd7);
    idle(3);

    // Streaming reads plus out-of-range write/read.
    for (int a = 0; a < 24; a++) set_op(1'b0, 5'd0, 23'h0, 3'b000, 1'b1, 5'(a));
    set_op(1'b1, 5'd30, 23'h2ABCDE, 3'b111, 1'b0, 5'd0);
    set_op(1'b0, 5'd0, 23'h0, 3'b000, 1'b1, 5'd30);
    idle(3);

    for (int i = 0; i < 600; i++) rand_op(1'b1);
    idle(3);

    // Reset from READY, then again ten cycles into the clear.
    set_op(1'b1, 5'd20, 23'h1ABCDE, 3'b111, 1'b0, 5'd0);
    set_op(1'b0, 5'd0, 23'h0, 3'b000, 1'b1, 5'd20);
    idle(2);
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    for (int i = 0; i < 10; i++) rand_op(1'b1);
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    idle(33);
    set_op(1'b0, 5'd0, 23'h0, 3'b000, 1'b1, 5'd20);
    for (int a = 0; a < 32; a++) set_op(1'b0, 5'd0, 23'h0, 3'b000, 1'b1, 5'(a));
    idle(5);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending reads exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
